// File: rtl/ping_pong_rd_ctrl.sv
// Read-side sequencer for the west/north ping-pong input banks of the attention matmul path.
// It streams one full bank into the systolic array, waits for the array to finish, then releases the bank.
module ping_pong_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int W_COL_X    = 4,
  parameter int N_COL_X    = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            bank_full,
  output logic [1:0]            bank_release,
  input  logic                  systolic_finish_wrap,
  output logic                  w_bank0_ena,
  output logic                  w_bank1_ena,
  output logic                  w_bank0_enb,
  output logic                  w_bank1_enb,
  output logic [ADDR_WIDTH-1:0] w_bank0_addra,
  output logic [ADDR_WIDTH-1:0] w_bank0_addrb,
  output logic [ADDR_WIDTH-1:0] w_bank1_addra,
  output logic [ADDR_WIDTH-1:0] w_bank1_addrb,
  output logic                  n_bank0_ena,
  output logic                  n_bank1_ena,
  output logic [ADDR_WIDTH-1:0] n_bank0_addra,
  output logic [ADDR_WIDTH-1:0] n_bank1_addra,
  output logic                  rd_bank_sel,
  output logic                  w_valid,
  output logic                  w_last,
  output logic                  n_valid,
  output logic                  n_last,
  output logic                  enable_matmul,
  output logic                  busy
);

  localparam int MAX_COL = (W_COL_X > N_COL_X) ? W_COL_X : N_COL_X;
  localparam int CNT_W   = $clog2(MAX_COL) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MAX_COL - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(W_COL_X - 1);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_COL_X - 1);
  localparam logic [CNT_W-1:0] W_CNT   = CNT_W'(W_COL_X);
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N_COL_X);
  localparam logic [1:0]       DR_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_COMPUTE,
    S_RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic                    next_bank_q, next_bank_d;
  logic                    en_q, en_d;
  logic [RD_LATENCY-1:0]   w_vld_q, w_vld_d;
  logic [RD_LATENCY-1:0]   w_lst_q, w_lst_d;
  logic [RD_LATENCY-1:0]   n_vld_q, n_vld_d;
  logic [RD_LATENCY-1:0]   n_lst_q, n_lst_d;

  logic                    rd_act;
  logic                    w_iss, w_lst_iss, n_iss, n_lst_iss;
  logic [ADDR_WIDTH-1:0]   w_addra, w_addrb, n_addra;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      next_bank_q <= 1'b0;
      en_q        <= 1'b0;
      w_vld_q     <= '0;
      w_lst_q     <= '0;
      n_vld_q     <= '0;
      n_lst_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      next_bank_q <= next_bank_d;
      en_q        <= en_d;
      w_vld_q     <= w_vld_d;
      w_lst_q     <= w_lst_d;
      n_vld_q     <= n_vld_d;
      n_lst_q     <= n_lst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    next_bank_d = next_bank_q;
    case (state_q)
      S_IDLE: begin
        // Only the bank whose turn it is may start a tile; the other bit is ignored.
        if (bank_full[next_bank_q]) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DR_LAST) state_d = S_COMPUTE;
        else                   dcnt_d  = dcnt_q + 1'b1;
      end
      S_COMPUTE: begin
        if (systolic_finish_wrap) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d     = S_IDLE;
        next_bank_d = ~next_bank_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue stage: read enables and addresses come straight from the counter.
  always_comb begin
    rd_act    = (state_q == S_READ);
    w_iss     = rd_act && (cnt_q < W_CNT);
    n_iss     = rd_act && (cnt_q < N_CNT);
    w_lst_iss = rd_act && (cnt_q == W_LAST);
    n_lst_iss = rd_act && (cnt_q == N_LAST);
    w_addra   = w_iss ? ADDR_WIDTH'(cnt_q) : '0;
    w_addrb   = w_iss ? (ADDR_WIDTH'(W_COL_X) + ADDR_WIDTH'(cnt_q)) : '0;
    n_addra   = n_iss ? ADDR_WIDTH'(cnt_q) : '0;
  end

  // Data stage: flags delayed by the BRAM read latency to line up with read data.
  always_comb begin
    w_vld_d[0] = w_iss;
    w_lst_d[0] = w_lst_iss;
    n_vld_d[0] = n_iss;
    n_lst_d[0] = n_lst_iss;
    for (int i = 1; i < RD_LATENCY; i++) begin
      w_vld_d[i] = w_vld_q[i-1];
      w_lst_d[i] = w_lst_q[i-1];
      n_vld_d[i] = n_vld_q[i-1];
      n_lst_d[i] = n_lst_q[i-1];
    end
  end

  always_comb begin
    w_valid = w_vld_q[RD_LATENCY-1];
    w_last  = w_lst_q[RD_LATENCY-1];
    n_valid = n_vld_q[RD_LATENCY-1];
    n_last  = n_lst_q[RD_LATENCY-1];
    en_d    = en_q;
    if (w_valid || n_valid) en_d = 1'b1;
    if ((state_q == S_COMPUTE) && systolic_finish_wrap) en_d = 1'b0;
  end

  assign enable_matmul = en_q | w_valid | n_valid;
  assign busy          = (state_q != S_IDLE);
  // next_bank only toggles on leaving S_RELEASE, so it names the active bank for the whole tile.
  assign rd_bank_sel   = next_bank_q;
  assign bank_release  = (state_q != S_RELEASE) ? 2'b00 : (next_bank_q ? 2'b10 : 2'b01);

  assign w_bank0_ena   = w_iss & ~next_bank_q;
  assign w_bank0_enb   = w_iss & ~next_bank_q;
  assign w_bank1_ena   = w_iss &  next_bank_q;
  assign w_bank1_enb   = w_iss &  next_bank_q;
  assign w_bank0_addra = next_bank_q ? '0 : w_addra;
  assign w_bank0_addrb = next_bank_q ? '0 : w_addrb;
  assign w_bank1_addra = next_bank_q ? w_addra : '0;
  assign w_bank1_addrb = next_bank_q ? w_addrb : '0;
  assign n_bank0_ena   = n_iss & ~next_bank_q;
  assign n_bank1_ena   = n_iss &  next_bank_q;
  assign n_bank0_addra = next_bank_q ? '0 : n_addra;
  assign n_bank1_addra = next_bank_q ? n_addra : '0;

endmodule

// File: tb/tb_ping_pong_rd_ctrl.sv
// Bench for ping_pong_rd_ctrl: three instances (W=N=4 L=1; W=4 N=2 L=1; W=N=4 L=3)
// checked cycle by cycle against a scoreboard of expected outputs derived from the tile timeline.
module tb_ping_pong_rd_ctrl;

  typedef struct packed {
    logic       w0_ena;
    logic       w0_enb;
    logic [3:0] w0_addra;
    logic [3:0] w0_addrb;
    logic       w1_ena;
    logic       w1_enb;
    logic [3:0] w1_addra;
    logic [3:0] w1_addrb;
    logic       n0_ena;
    logic [3:0] n0_addra;
    logic       n1_ena;
    logic [3:0] n1_addra;
    logic [1:0] rel;
    logic       sel;
    logic       w_valid;
    logic       w_last;
    logic       n_valid;
    logic       n_last;
    logic       en_mm;
    logic       busy;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   chk_sel;
    int   cyc;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     bf  [3];
  logic           fin [3];
  obs_t [2:0]     obs_all;

  int checks = 0;
  int errors = 0;
  rec_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       w0_ena, w0_enb, w1_ena, w1_enb, n0_ena, n1_ena;
    logic [3:0] w0_addra, w0_addrb, w1_addra, w1_addrb, n0_addra, n1_addra;
    logic [1:0] rel;
    logic       sel, w_valid, w_last, n_valid, n_last, en_mm, busy;

    ping_pong_rd_ctrl #(
      .ADDR_WIDTH (4),
      .W_COL_X    (4),
      .N_COL_X    ((g == 1) ? 2 : 4),
      .RD_LATENCY ((g == 2) ? 3 : 1)
    ) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .bank_full            (bf[g]),
      .bank_release         (rel),
      .systolic_finish_wrap (fin[g]),
      .w_bank0_ena          (w0_ena),
      .w_bank1_ena          (w1_ena),
      .w_bank0_enb          (w0_enb),
      .w_bank1_enb          (w1_enb),
      .w_bank0_addra        (w0_addra),
      .w_bank0_addrb        (w0_addrb),
      .w_bank1_addra        (w1_addra),
      .w_bank1_addrb        (w1_addrb),
      .n_bank0_ena          (n0_ena),
      .n_bank1_ena          (n1_ena),
      .n_bank0_addra        (n0_addra),
      .n_bank1_addra        (n1_addra),
      .rd_bank_sel          (sel),
      .w_valid              (w_valid),
      .w_last               (w_last),
      .n_valid              (n_valid),
      .n_last               (n_last),
      .enable_matmul        (en_mm),
      .busy                 (busy)
    );

    assign obs_all[g] = '{w0_ena: w0_ena, w0_enb: w0_enb, w0_addra: w0_addra, w0_addrb: w0_addrb,
                          w1_ena: w1_ena, w1_enb: w1_enb, w1_addra: w1_addra, w1_addrb: w1_addrb,
                          n0_ena: n0_ena, n0_addra: n0_addra, n1_ena: n1_ena, n1_addra: n1_addra,
                          rel: rel, sel: sel, w_valid: w_valid, w_last: w_last,
                          n_valid: n_valid, n_last: n_last, en_mm: en_mm, busy: busy};
  end

  function automatic int wof(int k); return 4; endfunction
  function automatic int nof(int k); return (k == 1) ? 2 : 4; endfunction
  function automatic int lof(int k); return (k == 2) ? 3 : 1; endfunction

  // Expected outputs in cycle c of a tile on bank b: cycle 1 is the first read issue,
  // finish is driven in cycle f, so release is f+1 and f+2 is idle again.
  function automatic rec_t exp_at(int k, int b, int c, int f);
    rec_t r;
    obs_t e;
    int w, n, l, m, j;
    w = wof(k);
    n = nof(k);
    l = lof(k);
    m = (w > n) ? w : n;
    j = c - 1;
    e = '0;
    if (c >= 1 && c <= m && j < w) begin
      if (b == 0) begin
        e.w0_ena = 1'b1; e.w0_enb = 1'b1; e.w0_addra = 4'(j); e.w0_addrb = 4'(w + j);
      end else begin
        e.w1_ena = 1'b1; e.w1_enb = 1'b1; e.w1_addra = 4'(j); e.w1_addrb = 4'(w + j);
      end
    end
    if (c >= 1 && c <= m && j < n) begin
      if (b == 0) begin e.n0_ena = 1'b1; e.n0_addra = 4'(j); end
      else        begin e.n1_ena = 1'b1; e.n1_addra = 4'(j); end
    end
    e.w_valid = (c >= 1 + l) && (c <= w + l);
    e.w_last  = (c == w + l);
    e.n_valid = (c >= 1 + l) && (c <= n + l);
    e.n_last  = (c == n + l);
    e.en_mm   = (c >= 1 + l) && (c <= f);
    e.busy    = (c >= 1) && (c <= f + 1);
    e.rel     = (c == f + 1) ? ((b == 0) ? 2'b01 : 2'b10) : 2'b00;
    e.sel     = (b != 0);
    r.o       = e;
    r.chk_sel = e.w_valid || e.n_valid || (c == f + 1);
    r.cyc     = c;
    return r;
  endfunction

  // Caller is at the falling edge of an idle cycle ("cycle 0").
  task automatic run_tile(input int k, input int b, input int f, input int sp1, input int sp2,
                          input string name);
    rec_t r;
    obs_t act, ex;
    bf[k][b] = 1'b1;
    for (int c = 1; c <= f + 2; c++) sb_q.push_back(exp_at(k, b, c, f));
    for (int c = 1; c <= f + 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      act = obs_all[k];
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s inst%0d cyc%0d: scoreboard empty", name, k, c);
      end else begin
        r  = sb_q.pop_front();
        ex = r.o;
        if (!r.chk_sel) begin
          act.sel = 1'b0;
          ex.sel  = 1'b0;
        end
        if (act !== ex) begin
          errors++;
          $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, k, r.cyc, act, ex);
        end
      end
      fin[k] = (c == f) || (c == sp1) || (c == sp2);
      if (c == f + 1) bf[k][b] = 1'b0;
    end
    fin[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bf[k]  = 2'b11;
      fin[k] = 1'b0;
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_all[k] !== obs_t'(0)) begin
          errors++;
          $display("FAIL reset inst%0d: got %h expected 0", k, obs_all[k]);
        end
      end
    end
  endtask

  task automatic test_ping_pong();
    rst_n = 1'b1;
    bf[0] = 2'b11;
    bf[1] = 2'b00;
    bf[2] = 2'b00;
    run_tile(0, 0, 9, 0, 0, "pp_bank0");
    run_tile(0, 1, 9, 0, 0, "pp_bank1");
    bf[0] = 2'b00;
  endtask

  task automatic test_unequal();
    run_tile(1, 0, 8, 0, 0, "unequal");
  endtask

  task automatic test_spurious_finish();
    run_tile(0, 0, 12, 2, 5, "spurious");
  endtask

  task automatic test_latency3();
    run_tile(2, 0, 10, 0, 0, "lat3");
  endtask

  task automatic test_reset_abort();
    rec_t r;
    obs_t act, ex;
    bf[2] = 2'b10;
    for (int c = 1; c <= 3; c++) sb_q.push_back(exp_at(2, 1, c, 10));
    for (int c = 4; c <= 5; c++) begin
      r.o = '0;
      r.chk_sel = 1'b1;
      r.cyc = c;
      sb_q.push_back(r);
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      act = obs_all[2];
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL abort cyc%0d: scoreboard empty", c);
      end else begin
        r  = sb_q.pop_front();
        ex = r.o;
        if (!r.chk_sel) begin
          act.sel = 1'b0;
          ex.sel  = 1'b0;
        end
        if (act !== ex) begin
          errors++;
          $display("FAIL abort cyc%0d: got %h expected %h", r.cyc, act, ex);
        end
      end
      if (c == 3) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    bf[2] = 2'b11;
    run_tile(2, 0, 10, 0, 0, "after_abort");
    bf[2] = 2'b00;
  endtask

  initial begin
    test_reset();
    test_ping_pong();
    test_unequal();
    test_spurious_finish();
    test_latency3();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
